// File: rtl/cache_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lc3b_types (package)
//  Description : Shared LC-3b types for the cache arbiter: word and memory
//                line typedefs, arbiter state encoding, streak constants.
//  Revision    : 1.0  initial release
// ============================================================================
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_mem_data;

    // Arbiter state encoding, explicit 2-bit width
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } lc3b_arb_state;

    localparam int         c_STREAK_W   = 4;
    localparam logic [3:0] c_STREAK_MAX = 4'hF;

endpackage : lc3b_types
`default_nettype wire

// File: rtl/cache_arbiter_perf.sv
`default_nettype none
// ============================================================================
//  Module      : cache_arbiter_perf
//  Description : Free-running performance counters for the cache arbiter:
//                I grants, D grants and IDLE cycles with both sides pending.
//                All counters wrap at 2^32. Only built when
//                CACHE_ARBITER_PERF_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module cache_arbiter_perf (
    input  logic        clk,
    input  logic        reset,
    input  logic        grant_i,
    input  logic        grant_d,
    input  logic        conflict,
    output logic [31:0] perf_i_grants,
    output logic [31:0] perf_d_grants,
    output logic [31:0] perf_conflicts
);

    logic [31:0] r_i_grants;
    logic [31:0] r_d_grants;
    logic [31:0] r_conflicts;

    // Count each event once per cycle; natural overflow gives the wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_i_grants  <= '0;
            r_d_grants  <= '0;
            r_conflicts <= '0;
        end else begin
            if (grant_i)  r_i_grants  <= r_i_grants + 32'd1;
            if (grant_d)  r_d_grants  <= r_d_grants + 32'd1;
            if (conflict) r_conflicts <= r_conflicts + 32'd1;
        end
    end

    assign perf_i_grants  = r_i_grants;
    assign perf_d_grants  = r_d_grants;
    assign perf_conflicts = r_conflicts;

endmodule : cache_arbiter_perf
`default_nettype wire

// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cache_arbiter
//  Description : Arbitrates one physical memory port between an I-cache and
//                a D-cache. D wins ties unless it has taken STARVE_LIMIT
//                consecutive grants while I was waiting. A grant is held until
//                memory responds; one IDLE cycle separates grants.
//                Optional feature macro: CACHE_ARBITER_PERF_EN (perf counters).
//  Revision    : 1.0  initial release
// ============================================================================
module cache_arbiter
    import lc3b_types::*;
#(
    parameter int unsigned STARVE_LIMIT = 4   // legal range 1..15
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         i_pmem_read,
    input  lc3b_word     i_pmem_address,
    output lc3b_mem_data i_pmem_rdata,
    output logic         i_pmem_resp,

    input  logic         d_pmem_read,
    input  logic         d_pmem_write,
    input  lc3b_word     d_pmem_address,
    input  lc3b_mem_data d_pmem_wdata,
    output lc3b_mem_data d_pmem_rdata,
    output logic         d_pmem_resp,

    output logic         pmem_read,
    output logic         pmem_write,
    output lc3b_word     pmem_address,
    output lc3b_mem_data pmem_wdata,
    input  lc3b_mem_data pmem_rdata,
    input  logic         pmem_resp,

    output logic [31:0]  perf_i_grants,
    output logic [31:0]  perf_d_grants,
    output logic [31:0]  perf_conflicts
);

    localparam logic [c_STREAK_W-1:0] c_LIMIT = c_STREAK_W'(STARVE_LIMIT);

    lc3b_arb_state         r_state;
    lc3b_arb_state         w_next_state;
    logic [c_STREAK_W-1:0] r_d_streak;

    logic w_i_pend;
    logic w_d_pend;
    logic w_grant_i;
    logic w_grant_d;

    assign w_i_pend  = i_pmem_read;
    assign w_d_pend  = d_pmem_read | d_pmem_write;
    assign w_grant_i = (r_state == IDLE) && (w_next_state == SERVE_I);
    assign w_grant_d = (r_state == IDLE) && (w_next_state == SERVE_D);

    // Read data fans out to both caches unconditionally; resp qualifies it
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

    // State register; async reset drops any in-flight grant immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // D streak: counts D wins over a waiting I, cleared whenever I is granted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_d_streak <= '0;
        end else if (w_grant_i) begin
            r_d_streak <= '0;
        end else if (w_grant_d && w_i_pend && (r_d_streak != c_STREAK_MAX)) begin
            r_d_streak <= r_d_streak + 1'b1;
        end
    end

    // Next-state arbitration and memory-port steering by current owner
    always_comb begin
        w_next_state = r_state;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_i_pend && w_d_pend) begin
                    w_next_state = (r_d_streak == c_LIMIT) ? SERVE_I : SERVE_D;
                end else if (w_i_pend) begin
                    w_next_state = SERVE_I;
                end else if (w_d_pend) begin
                    w_next_state = SERVE_D;
                end
            end
            SERVE_I: begin
                pmem_read    = 1'b1;
                pmem_address = i_pmem_address;
                i_pmem_resp  = pmem_resp;
                // Grant is held until memory completes, even if I drops
                if (pmem_resp) w_next_state = IDLE;
            end
            SERVE_D: begin
                // Read/write forwarded untouched, including the illegal pair
                pmem_read    = d_pmem_read;
                pmem_write   = d_pmem_write;
                pmem_address = d_pmem_address;
                pmem_wdata   = d_pmem_wdata;
                d_pmem_resp  = pmem_resp;
                if (pmem_resp) w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

`ifdef CACHE_ARBITER_PERF_EN
    logic w_conflict;
    assign w_conflict = (r_state == IDLE) && w_i_pend && w_d_pend;

    cache_arbiter_perf u_perf (
        .clk            (clk),
        .reset          (reset),
        .grant_i        (w_grant_i),
        .grant_d        (w_grant_d),
        .conflict       (w_conflict),
        .perf_i_grants  (perf_i_grants),
        .perf_d_grants  (perf_d_grants),
        .perf_conflicts (perf_conflicts)
    );
`else
    assign perf_i_grants  = '0;
    assign perf_d_grants  = '0;
    assign perf_conflicts = '0;
`endif

endmodule : cache_arbiter
`default_nettype wire

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, maximum consecutive D-cache grants while an I-cache request waits; legal range 1..15.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 i_pmem_read  in  1  I-cache line-fill request, held until i_pmem_resp.
REQ-005 i_pmem_address  in  16 (lc3b_word)  I-cache line address.
REQ-006 i_pmem_rdata  out  128 (lc3b_mem_data)  line data to I-cache.
REQ-007 i_pmem_resp  out  1  I-cache transaction complete.
REQ-008 d_pmem_read / d_pmem_write  in  1 each  D-cache fill / writeback request, held until d_pmem_resp.
REQ-009 d_pmem_address  in  16  D-cache line address; d_pmem_wdata  in  128  writeback data.
REQ-010 d_pmem_rdata  out  128; d_pmem_resp  out  1  D-cache data and completion.
REQ-011 pmem_read, pmem_write  out  1 each; pmem_address  out  16; pmem_wdata  out  128  physical memory request.
REQ-012 pmem_rdata  in  128; pmem_resp  in  1  physical memory data and completion.
REQ-013 perf_i_grants, perf_d_grants, perf_conflicts  out  32 each  performance counters (see Configuration).

Function
REQ-014 The FSM SHALL have states IDLE, SERVE_I, SERVE_D.
REQ-015 In IDLE, outputs SHALL be pmem_read=0, pmem_write=0, i_pmem_resp=0, d_pmem_resp=0.
REQ-016 In IDLE with only I pending, next state SHALL be SERVE_I; with only D pending (read or write), SERVE_D; with neither, IDLE.
REQ-017 In IDLE with both pending, D SHALL win unless d_streak == STARVE_LIMIT, in which case I SHALL win.
REQ-018 d_streak (4-bit) SHALL increment on each D grant made while I is pending, saturate at 15, and clear on every I grant.
REQ-019 In SERVE_I: pmem_read=1, pmem_write=0, pmem_address=i_pmem_address; in SERVE_D: pmem_read=d_pmem_read, pmem_write=d_pmem_write, pmem_address=d_pmem_address, pmem_wdata=d_pmem_wdata.
REQ-020 pmem_rdata SHALL drive i_pmem_rdata and d_pmem_rdata combinationally at all times.
REQ-021 x_pmem_resp SHALL equal pmem_resp combinationally only while in SERVE_x; the other side's resp SHALL stay 0.
REQ-022 On pmem_resp in SERVE_x, next state SHALL be IDLE; minimum turnaround is one IDLE cycle between grants.
REQ-023 Latency: request sampled in IDLE at edge N; pmem request visible in cycle N+1.
REQ-024 If the owner drops its request before pmem_resp, the arbiter SHALL keep the grant until pmem_resp (memory must complete).
REQ-025 Simultaneous d_pmem_read and d_pmem_write is illegal; both SHALL be forwarded unmodified.

Reset
REQ-026 On reset assertion, state SHALL become IDLE and d_streak 0 immediately, forcing all pmem and resp outputs to 0 without waiting for clk.
REQ-027 Reset mid-transaction SHALL abandon the transaction; no resp SHALL be issued for it after release.
REQ-028 Perf counters SHALL reset to 0.

Configuration
REQ-029 Macro CACHE_ARBITER_PERF_EN: when defined, perf_i_grants/perf_d_grants SHALL count grants to I/D, perf_conflicts SHALL count IDLE cycles with both pending, all wrapping at 2^32.
REQ-030 When CACHE_ARBITER_PERF_EN is undefined, the three perf outputs SHALL be constant 0 and no counter flops SHALL be built.

Structure
REQ-031 The state enum lc3b_arb_state (IDLE, SERVE_I, SERVE_D) SHALL live in package lc3b_types; address/data ports SHALL use lc3b_word and lc3b_mem_data.
REQ-032 The counters SHALL be one sub-module, cache_arbiter_perf, instantiated only under CACHE_ARBITER_PERF_EN.

Verification
REQ-033 I read alone, addr 0x1230, memory resp after 3 cycles with data 0xA5..A5 -> pmem_read from N+1, i_pmem_resp=1 exactly one cycle with rdata 0xA5..A5, d_pmem_resp=0.
REQ-034 I and D read asserted same cycle -> D served first, then IDLE, then I served; perf_conflicts >=1 with PERF_EN.
REQ-035 I held, D re-requests back-to-back, STARVE_LIMIT=4 -> exactly 4 D grants, then I granted on 5th arbitration.
REQ-036 D write addr 0x4440 wdata 0x0123..EF -> pmem_write=1, pmem_address=0x4440, pmem_wdata matches until resp; pmem_read=0.
REQ-037 Reset asserted mid-SERVE_D between edges -> pmem_write falls in same cycle; after release, state IDLE, no d_pmem_resp.
REQ-038 Build without CACHE_ARBITER_PERF_EN, run REQ-034 -> all perf outputs remain 0.
